uart_word_bridge: RTL

- Parametrised word/byte bridge between the core data path and byte-wide UART TX/RX engines.
- TX side: buffers up to TX_DEPTH words, then serialises each word into DATA_WIDTH/8 bytes using the UART byte handshake.
- RX side: assembles received bytes into words, with a ready/valid output, an overrun flag and an optional inter-byte timeout.
- Clock domain: replaces the fixed 32-bit single-word path; runs entirely in the system clock domain.

---
 rtl/uart_word_bridge.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_word_bridge.sv
// Word/byte bridge between the core data path and byte-wide UART TX/RX engines.
// TX words are queued in a small FIFO and sent byte by byte; RX bytes are assembled into words.
module uart_word_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int TX_DEPTH   = 4,
  parameter int MSB_FIRST  = 0,
  parameter int RX_TIMEOUT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     tx_word_i,
  input  logic                      tx_wr_i,
  output logic                      tx_full_o,
  output logic [$clog2(TX_DEPTH):0] tx_count_o,
  output logic                      tx_ovf_o,
  output logic [7:0]                uart_dat_o,
  output logic                      uart_wr_o,
  input  logic                      uart_busy_i,
  input  logic                      uart_done_i,
  input  logic [7:0]                rx_byte_i,
  input  logic                      rx_dv_i,
  output logic [DATA_WIDTH-1:0]     rx_word_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic                      rx_overrun_o,
  output logic                      rx_timeout_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam int TMO_LAST_I = (RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(TX_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LAST_I);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_REQ,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

  tx_state_t tx_state, tx_next;

  logic [DATA_WIDTH-1:0] fifo_mem [TX_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  fifo_full, fifo_empty, push, pop;

  logic [DATA_WIDTH-1:0] tx_shift;
  logic [IW-1:0]         tx_idx, tx_lane;
  logic                  tx_last, byte_done;

  logic [DATA_WIDTH-1:0] rx_acc, rx_word_next;
  logic [IW-1:0]         rx_idx, rx_idx_eff, rx_lane;
  logic [TW-1:0]         tmo_cnt;
  logic                  tmo_expire, out_free, word_done;

  // Full is taken from registered occupancy, so a pop in the same cycle never frees a slot.
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = tx_wr_i && !fifo_full;
  assign pop        = (tx_state == TX_LOAD);
  assign tx_full_o  = fifo_full;
  assign tx_count_o = count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ovf_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (tx_wr_i && fifo_full) tx_ovf_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= tx_word_i;
  end

  assign tx_last   = (tx_idx == LAST_IDX);
  assign byte_done = uart_done_i && ((tx_state == TX_WAIT_BUSY) || (tx_state == TX_WAIT_DONE));

  always_ff @(posedge clk) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  // A done pulse seen while still waiting for busy is treated as a complete byte.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:      if (!fifo_empty) tx_next = TX_LOAD;
      TX_LOAD:      tx_next = TX_REQ;
      TX_REQ:       tx_next = TX_WAIT_BUSY;
      TX_WAIT_BUSY: begin
        if (uart_done_i)      tx_next = tx_last ? TX_IDLE : TX_REQ;
        else if (uart_busy_i) tx_next = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: if (uart_done_i) tx_next = tx_last ? TX_IDLE : TX_REQ;
      default:      tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_shift <= '0;
      tx_idx   <= '0;
    end else if (pop) begin
      tx_shift <= fifo_mem[rd_ptr];
      tx_idx   <= '0;
    end else if (byte_done && !tx_last) begin
      tx_idx <= tx_idx + 1'b1;
    end
  end

  // The byte select only moves on LOAD or a completed byte, keeping uart_dat_o stable between requests.
  always_comb begin
    tx_lane    = (MSB_FIRST != 0) ? (LAST_IDX - tx_idx) : tx_idx;
    uart_dat_o = tx_shift[8*int'(tx_lane) +: 8];
    uart_wr_o  = (tx_state == TX_REQ) && rst;
  end

  assign tmo_expire = (RX_TIMEOUT > 0) && (rx_idx != '0) && (tmo_cnt == TMO_LAST);
  assign out_free   = !rx_valid_o || rx_ready_i;

  // On expiry the incoming byte, if any, starts a fresh word in lane 0.
  always_comb begin
    rx_idx_eff   = tmo_expire ? '0 : rx_idx;
    rx_lane      = (MSB_FIRST != 0) ? (LAST_IDX - rx_idx_eff) : rx_idx_eff;
    rx_word_next = tmo_expire ? '0 : rx_acc;
    rx_word_next[8*int'(rx_lane) +: 8] = rx_byte_i;
    word_done    = rx_dv_i && (rx_idx_eff == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_acc       <= '0;
      rx_idx       <= '0;
      tmo_cnt      <= '0;
      rx_word_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
      rx_timeout_o <= 1'b0;
    end else begin
      rx_timeout_o <= tmo_expire;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      if (rx_dv_i) begin
        if (word_done) begin
          rx_idx <= '0;
          rx_acc <= '0;
          if (out_free) begin
            rx_word_o  <= rx_word_next;
            rx_valid_o <= 1'b1;
          end else begin
            rx_overrun_o <= 1'b1;
          end
        end else begin
          rx_idx <= rx_idx_eff + 1'b1;
          rx_acc <= rx_word_next;
        end
      end else if (tmo_expire) begin
        rx_idx <= '0;
        rx_acc <= '0;
      end
      if (rx_dv_i || tmo_expire || (rx_idx == '0)) tmo_cnt <= '0;
      else                                         tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule
